iterative_alu: RTL and testbench



---
 rtl/iterative_alu.sv | 188 ++++++++++++++++++
 tb/tb_iterative_alu.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/iterative_alu.sv
// Execute-stage ALU with valid/ready issue: single-cycle logic/arith/shift/compare
// ops plus iterative shift-add multiply and restoring divide over DATA_WIDTH steps.
module iterative_alu #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Valid_i,
  output logic                  Ready_o,
  input  logic [4:0]            ALU_Operation_i,
  input  logic [DATA_WIDTH-1:0] A_i,
  input  logic [DATA_WIDTH-1:0] B_i,
  output logic                  Valid_o,
  output logic [DATA_WIDTH-1:0] Result_o,
  output logic                  Zero_o
);
  localparam int W = DATA_WIDTH;

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00000, OP_SUB  = 5'b00001, OP_AND  = 5'b00010, OP_OR   = 5'b00011,
    OP_XOR  = 5'b00100, OP_LUI  = 5'b00101, OP_SRL  = 5'b00110, OP_SLL  = 5'b00111,
    OP_SRA  = 5'b01000, OP_SLT  = 5'b01001, OP_SLTU = 5'b01010, OP_MUL  = 5'b01011,
    OP_MULH = 5'b01100, OP_DIV  = 5'b01101, OP_DIVU = 5'b01110, OP_REM  = 5'b01111,
    OP_REMU = 5'b10000
  } alu_op_e;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e                 state_q, state_d;
  alu_op_e                op_q, op_d;
  logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]         acc_q, acc_d;
  logic [W-1:0]           opnd_q, opnd_d;
  logic                   neg_q, neg_d;
  logic [W-1:0]           result_q, result_d;
  logic                   zero_q, zero_d;

  alu_op_e                op_in;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic [W-1:0]           single_res;
  logic                   accept;
  logic                   in_mul, in_div, in_quot, in_signed;
  logic                   a_neg, b_neg;
  logic [W-1:0]           a_abs, b_abs;

  assign op_in  = alu_op_e'(ALU_Operation_i);
  assign shamt  = B_i[SHAMT_WIDTH-1:0];
  assign accept = Valid_i && Ready_o;

  assign in_mul    = op_in inside {OP_MUL, OP_MULH};
  assign in_div    = op_in inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign in_quot   = op_in inside {OP_DIV, OP_DIVU};
  assign in_signed = op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  assign a_neg     = in_signed && A_i[W-1];
  assign b_neg     = in_signed && B_i[W-1];
  assign a_abs     = a_neg ? -A_i : A_i;
  assign b_abs     = b_neg ? -B_i : B_i;

  always_comb begin
    single_res = '0;
    case (op_in)
      OP_ADD:  single_res = A_i + B_i;
      OP_SUB:  single_res = A_i - B_i;
      OP_AND:  single_res = A_i & B_i;
      OP_OR:   single_res = A_i | B_i;
      OP_XOR:  single_res = A_i ^ B_i;
      OP_LUI:  single_res = B_i << 12;
      OP_SRL:  single_res = A_i >> shamt;
      OP_SLL:  single_res = A_i << shamt;
      OP_SRA:  single_res = W'($signed(A_i) >>> shamt);
      OP_SLT:  single_res = W'($signed(A_i) < $signed(B_i));
      OP_SLTU: single_res = W'(A_i < B_i);
      default: single_res = '0;
    endcase
  end

  // Iteration datapath. Multiply: acc = {partial product, remaining multiplier},
  // opnd = |multiplicand|. Divide: acc = {partial remainder, dividend/quotient},
  // opnd = |divisor|; a zero divisor naturally yields all-ones and the dividend.
  logic [W:0]     mul_sum;
  logic [W:0]     rem_shift;
  logic           rem_ge;
  logic [W-1:0]   rem_diff;
  logic [2*W-1:0] step_acc;
  logic [2*W-1:0] prod_s;
  logic [W-1:0]   quo, rem, final_res;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rem_shift = {acc_q[2*W-1:W], acc_q[W-1]};
    rem_ge    = rem_shift >= {1'b0, opnd_q};
    rem_diff  = rem_shift[W-1:0] - opnd_q;
    if (op_q inside {OP_MUL, OP_MULH}) begin
      step_acc = {mul_sum, acc_q[W-1:1]};
    end else if (rem_ge) begin
      step_acc = {rem_diff, acc_q[W-2:0], 1'b1};
    end else begin
      step_acc = {rem_shift[W-1:0], acc_q[W-2:0], 1'b0};
    end
  end

  always_comb begin
    prod_s = neg_q ? -step_acc : step_acc;
    quo    = step_acc[W-1:0];
    rem    = step_acc[2*W-1:W];
    case (op_q)
      OP_MUL:          final_res = prod_s[W-1:0];
      OP_MULH:         final_res = prod_s[2*W-1:W];
      OP_DIV, OP_DIVU: final_res = neg_q ? -quo : quo;
      default:         final_res = neg_q ? -rem : rem;
    endcase
  end

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      CALC: begin
        acc_d = step_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SHAMT_WIDTH'(W - 1)) begin
          state_d  = DONE;
          cnt_d    = '0;
          result_d = final_res;
          zero_d   = (final_res == '0);
        end
      end
      default: begin
        // IDLE and DONE both accept; DONE without a new request falls back to IDLE.
        state_d = IDLE;
        if (accept) begin
          op_d = op_in;
          if (in_mul || in_div) begin
            state_d = CALC;
            cnt_d   = '0;
            acc_d   = {{W{1'b0}}, in_mul ? b_abs : a_abs};
            opnd_d  = in_mul ? a_abs : b_abs;
            if (in_mul)       neg_d = a_neg ^ b_neg;
            else if (in_quot) neg_d = (a_neg ^ b_neg) && (B_i != '0);
            else              neg_d = a_neg;
          end else begin
            state_d  = DONE;
            result_d = single_res;
            zero_d   = (single_res == '0);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the datapath registers are reset too so an aborted operation leaves no stale state behind.
      state_q  <= IDLE;
      op_q     <= OP_ADD;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign Ready_o  = (state_q != CALC);
  assign Valid_o  = (state_q == DONE);
  assign Result_o = result_q;
  assign Zero_o   = zero_q;

endmodule

// File: tb/tb_iterative_alu.sv
// Directed bench for iterative_alu: 32-bit and 16-bit instances, hand-computed
// results, latency counted in clock edges from the accepting edge.
module tb_iterative_alu;
  localparam logic [4:0] ADD  = 5'b00000, SUB  = 5'b00001, LUI  = 5'b00101,
                         SRA  = 5'b01000, SLT  = 5'b01001, SLTU = 5'b01010,
                         MUL  = 5'b01011, MULH = 5'b01100, DIV  = 5'b01101,
                         DIVU = 5'b01110, REM  = 5'b01111, REMU = 5'b10000,
                         BAD  = 5'b11111;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        v32_i, rdy32, vo32, z32;
  logic [4:0]  op32;
  logic [31:0] a32, b32, res32;
  logic        v16_i, rdy16, vo16, z16;
  logic [4:0]  op16;
  logic [15:0] a16, b16, res16;

  int n_tests = 0;
  int n_fail  = 0;

  iterative_alu #(.DATA_WIDTH(32)) u_alu32 (
    .clk(clk), .reset(rst_n), .Valid_i(v32_i), .Ready_o(rdy32),
    .ALU_Operation_i(op32), .A_i(a32), .B_i(b32),
    .Valid_o(vo32), .Result_o(res32), .Zero_o(z32)
  );

  iterative_alu #(.DATA_WIDTH(16)) u_alu16 (
    .clk(clk), .reset(rst_n), .Valid_i(v16_i), .Ready_o(rdy16),
    .ALU_Operation_i(op16), .A_i(a16), .B_i(b16),
    .Valid_o(vo16), .Result_o(res16), .Zero_o(z16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op on the 32-bit instance and check result, zero flag, latency
  // and pulse width. With disturb set, inputs are scrambled and Valid_i is
  // raised while the op is still computing.
  task automatic run32(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                       input bit disturb);
    int lat;
    bit seen;
    @(negedge clk);
    check({tag, "_ready"}, 32'(rdy32), 32'd1);
    v32_i = 1'b1; op32 = op; a32 = a; b32 = b;
    @(posedge clk);
    lat = 0; seen = 1'b0;
    while (!seen && lat < 200) begin
      @(negedge clk);
      lat++;
      if (vo32) seen = 1'b1;
      if (lat == 1 && exp_lat > 1) check({tag, "_busy"}, 32'(rdy32), 32'd0);
      if (disturb && !seen) begin
        v32_i = 1'b1; op32 = ADD; a32 = $urandom; b32 = $urandom;
      end else begin
        v32_i = 1'b0;
      end
    end
    check({tag, "_valid"}, 32'(seen), 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, res32, exp);
    check({tag, "_zero"}, 32'(z32), 32'(exp == 32'd0));
    @(negedge clk);
    check({tag, "_pulse"}, 32'(vo32), 32'd0);
  endtask

  task automatic run16(input string tag, input logic [4:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] exp, input int exp_lat);
    int lat;
    bit seen;
    @(negedge clk);
    v16_i = 1'b1; op16 = op; a16 = a; b16 = b;
    @(posedge clk);
    lat = 0; seen = 1'b0;
    while (!seen && lat < 200) begin
      @(negedge clk);
      lat++;
      v16_i = 1'b0;
      if (vo16) seen = 1'b1;
    end
    check({tag, "_valid"}, 32'(seen), 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, 32'(res16), 32'(exp));
    check({tag, "_zero"}, 32'(z16), 32'(exp == 16'd0));
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0;
    v32_i = 1'b0; op32 = '0; a32 = '0; b32 = '0;
    v16_i = 1'b0; op16 = '0; a16 = '0; b16 = '0;
    #12;
    check("rst_ready", 32'(rdy32), 32'd1);
    check("rst_valid", 32'(vo32), 32'd0);
    check("rst_result", res32, 32'd0);
    check("rst_zero", 32'(z32), 32'd1);
    check("rst16_result", 32'(res16), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD then SUB on consecutive edges: two back-to-back valid pulses.
    @(negedge clk);
    v32_i = 1'b1; op32 = ADD; a32 = 32'h7FFF_FFFF; b32 = 32'h0000_0001;
    @(posedge clk);
    @(negedge clk);
    check("add_valid", 32'(vo32), 32'd1);
    check("add_res", res32, 32'h8000_0000);
    check("add_zero", 32'(z32), 32'd0);
    op32 = SUB; a32 = 32'd5; b32 = 32'd5;
    @(posedge clk);
    @(negedge clk);
    check("sub_valid", 32'(vo32), 32'd1);
    check("sub_res", res32, 32'd0);
    check("sub_zero", 32'(z32), 32'd1);
    v32_i = 1'b0;
    @(negedge clk);
    check("b2b_end", 32'(vo32), 32'd0);

    // Single-cycle class.
    run32("sra",  SRA,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1, 1'b0);
    run32("sltu", SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1, 1'b0);
    run32("slt_t", SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1, 1'b0);
    run32("slt_f", SLT, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1, 1'b0);
    // B shifted left by 12: 0x000ABCDE -> 0xABCDE000.
    run32("lui",  LUI,  32'h1234_5678, 32'h000A_BCDE, 32'hABCD_E000, 1, 1'b0);
    run32("bad",  BAD,  32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1, 1'b0);

    // Iterative multiply, first with inputs disturbed during the calculation.
    run32("mul",  MUL,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFEB, 33, 1'b1);
    run32("mulh", MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 1'b0);

    // Reset during cycle 10 of a multiply aborts it without a result pulse.
    @(negedge clk);
    v32_i = 1'b1; op32 = MUL; a32 = 32'd1234; b32 = 32'd5678;
    @(posedge clk);
    repeat (10) begin
      @(negedge clk);
      v32_i = 1'b0;
    end
    check("abort_busy", 32'(rdy32), 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort_ready", 32'(rdy32), 32'd1);
    check("abort_valid", 32'(vo32), 32'd0);
    check("abort_result", res32, 32'd0);
    check("abort_zero", 32'(z32), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (vo32) pulses++;
    end
    check("abort_no_pulse", 32'(pulses), 32'd0);

    // Divide, remainder and their boundary cases.
    run32("div",     DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33, 1'b0);
    run32("rem",     REM,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33, 1'b0);
    run32("divu_z",  DIVU, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 33, 1'b0);
    run32("remu_z",  REMU, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 33, 1'b0);
    run32("div_z",   DIV,  32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF, 33, 1'b0);
    run32("rem_z",   REM,  32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 33, 1'b0);
    run32("div_ovf", DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 1'b0);
    run32("rem_ovf", REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33, 1'b0);

    // 16-bit instance.
    run16("mul16",  MUL,  16'h00FF, 16'h0101, 16'hFFFF, 17);
    run16("divu16", DIVU, 16'hFFFF, 16'h0010, 16'h0FFF, 17);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
